// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the UART byte FIFO.
// Optional error flags are enabled by defining UART_FIFO_ERR_FLAGS_EN.
package uart_fifo_pkg;

  localparam int FIFO_MODE_REG   = 0;
  localparam int FIFO_MODE_FWFT  = 1;
  localparam int UART_FIFO_WIDTH = 8;
  localparam int UART_FIFO_DEPTH = 16;

  // Explicit wrap keeps non-power-of-2 depths correct.
  function automatic int unsigned fifo_ptr_inc(input int unsigned ptr, input int unsigned depth);
    if (ptr == (depth - 32'd1)) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read address.
// Used by uart_fifo_ctl (error flags selected there by UART_FIFO_ERR_FLAGS_EN).
module uart_fifo_ram
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH = UART_FIFO_WIDTH,
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_fifo_ctl.sv
// Parametrised UART byte FIFO with level, thresholds and registered or FWFT read.
// Define UART_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags.
module uart_fifo_ctl
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH = UART_FIFO_WIDTH,
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int FWFT  = FIFO_MODE_REG,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_wr_ready,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  input  logic [LVL_W-1:0] i_af_thresh,
  input  logic [LVL_W-1:0] i_ae_thresh,
  output logic [LVL_W-1:0] o_level,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_almostfull,
`ifdef UART_FIFO_ERR_FLAGS_EN
  input  logic             i_err_clr,
  output logic             o_overflow,
  output logic             o_underflow,
`endif
  output logic             o_almostempty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [LVL_W-1:0] r_level;
  logic [WIDTH-1:0] w_ram_data;
  logic             w_empty;
  logic             w_full;
  logic             w_rd_acc;
  logic             w_wr_acc;

  assign w_empty  = (r_level == LVL_W'(0));
  assign w_full   = (r_level == LVL_W'(DEPTH));
  // No bypass: an empty FIFO never accepts a read, even alongside a write.
  assign w_rd_acc = i_rd_en && !w_empty;
  assign w_wr_acc = i_wr_en && (!w_full || w_rd_acc);

  assign o_wr_ready    = !w_full || w_rd_acc;
  assign o_level       = r_level;
  assign o_empty       = w_empty;
  assign o_full        = w_full;
  assign o_almostfull  = (r_level >= i_af_thresh);
  assign o_almostempty = (r_level <= i_ae_thresh);

  uart_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_data)
  );

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= PTR_W'(fifo_ptr_inc(32'(r_wr_ptr), 32'(DEPTH)));
      end
      if (w_rd_acc) begin
        r_rd_ptr <= PTR_W'(fifo_ptr_inc(32'(r_rd_ptr), 32'(DEPTH)));
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign o_rd_data  = w_ram_data;
    assign o_rd_valid = !w_empty;
  end else begin : g_reg
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    // Registered read: one-cycle valid pulse, data held between reads.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) begin
          r_rd_data <= w_ram_data;
        end
      end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
  end

`ifdef UART_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags; a new error beats a coincident clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_wr_en && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end else if (i_err_clr) begin
        r_overflow <= 1'b0;
      end
      if (i_rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end else if (i_err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`endif

endmodule

// File: doc/uart_fifo_ctl.md
Name: uart_fifo_ctl

Overview:
Parametrised successor to the UART byte FIFO, used as the RX/TX buffer between the UART PHY and the case-converter datapath.
- Adds arbitrary (non-power-of-2) depth and a fill-level output.
- Adds programmable almost-full / almost-empty thresholds.
- Defines simultaneous read/write behaviour at every boundary.
- Offers a selectable first-word-fall-through (FWFT) read mode.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 16, number of entries (>=2, need not be a power of 2)
FWFT, 0, 0 = registered-read mode; 1 = first-word-fall-through mode
LVL_W, $clog2(DEPTH+1), width of level and threshold signals (derived; do not override)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous active-high reset
i_wr_en  in  1  write request
i_wr_data  in  WIDTH  write data
o_wr_ready  out  1  write will be accepted this cycle
i_rd_en  in  1  read request (mode 0) / pop acknowledge (FWFT)
o_rd_data  out  WIDTH  read data
o_rd_valid  out  1  read data valid
i_af_thresh  in  LVL_W  almost-full threshold
i_ae_thresh  in  LVL_W  almost-empty threshold
o_level  out  LVL_W  current occupancy, 0..DEPTH
o_empty  out  1  level == 0
o_full  out  1  level == DEPTH
o_almostfull  out  1  level >= i_af_thresh
o_almostempty  out  1  level <= i_ae_thresh

Behaviour:
- Reset (i_rst high at clock edge) sets:
  - rd_ptr = 0, wr_ptr = 0, level = 0
  - o_rd_valid = 0, o_rd_data = 0
  - Consequently o_empty = 1, o_full = 0. Memory contents are not cleared.
- Reset has priority over any concurrent read or write; an in-flight mode-0 read is dropped.
- Pointers increment modulo DEPTH: value DEPTH-1 wraps to 0 explicitly, with no reliance on natural binary overflow.
- Read and write accept rules:
  - rd_acc = i_rd_en && !o_empty. No bypass: reading an empty FIFO does nothing, even if a write occurs the same cycle.
  - wr_acc = i_wr_en && (!o_full || rd_acc). Writing while full succeeds only if a read is accepted in the same cycle.
  - o_wr_ready = !o_full || rd_acc.
- Level update each cycle:
  - wr_acc only: +1
  - rd_acc only: -1
  - both, or neither: unchanged
- Status flags:
  - o_level, o_empty, o_full, o_almostfull and o_almostempty are combinational from the registered level.
  - Thresholds are sampled live, with no latching.
- Mode 0 (FWFT=0):
  - On rd_acc, o_rd_data <= mem[rd_ptr] and o_rd_valid <= 1 at the next edge; latency is 1 cycle.
  - o_rd_valid is a single-cycle pulse per accepted read.
  - o_rd_data holds its last value when no read is accepted.
  - Back-to-back reads sustain 1 word per cycle.
- Mode 1 (FWFT=1):
  - o_rd_valid = !o_empty.
  - o_rd_data = mem[rd_ptr], combinational from the storage array.
  - i_rd_en while valid pops the head. The next word is presented the following cycle.
  - A word written into an empty FIFO becomes visible 1 cycle after the write edge.
  - The reset value of o_rd_data is don't-care in FWFT mode.
- Write data: wr_acc writes mem[wr_ptr] at the edge. A rejected write leaves the FIFO unchanged and is silently dropped, unless error flags are enabled (see Optional Feature).

Optional Feature:
Macro UART_FIFO_ERR_FLAGS_EN.
- When defined, three ports are added:
  - i_err_clr  in  1: clears the sticky flags
  - o_overflow  out  1: sticky; set the cycle after i_wr_en && !wr_acc
  - o_underflow  out  1: sticky; set the cycle after i_rd_en && o_empty
- Both flags reset to 0.
- If i_err_clr coincides with a new error in the same cycle, the set wins (the flag stays 1).
- When undefined, these ports and their logic are absent and illegal requests are silently ignored.

Decomposition:
- Package uart_fifo_pkg holds:
  - function fifo_ptr_inc(ptr, depth), the modulo wrap
  - localparam FIFO_MODE_REG = 0 and localparam FIFO_MODE_FWFT = 1
  - the default width/depth constants shared with the UART top
- One sub-module, uart_fifo_ram: a simple dual-port array with one write port and an asynchronous read address.
  - FWFT mode uses its combinational output directly.
  - Mode 0 registers that output in the parent.

Test Plan:
- Mode 0, DEPTH=16: write 0x41..0x50 (16 words) -> o_full=1, o_level=16, o_wr_ready=0; a 17th write is dropped; 16 reads return 0x41..0x50 in order, each o_rd_valid 1 cycle after i_rd_en; then o_empty=1.
- DEPTH=5 wrap: write 3, read 3, then write 5 -> pointers wrap past index 4; readback order intact, o_level sequence 1,2,3,2,1,0,1..5.
- Simultaneous events:
  - Read+write when full (level 16) -> level stays 16, both accepted.
  - Read+write when empty -> only the write is accepted, level becomes 1, o_rd_valid stays 0.
- Thresholds: i_af_thresh=12, i_ae_thresh=2; fill 0->16 -> o_almostempty high for levels 0-2, o_almostfull high from level 12; change i_af_thresh to 4 at level 8 -> o_almostfull rises the same cycle.
- FWFT=1: write 0x61 into an empty FIFO -> next cycle o_rd_valid=1, o_rd_data=0x61 with no i_rd_en; pulse i_rd_en -> o_rd_valid=0 the next cycle.
- Reset mid-stream at level 7, with a read issued that cycle -> next cycle o_level=0, o_empty=1, o_rd_valid=0; with UART_FIFO_ERR_FLAGS_EN, a read on empty then sets o_underflow, and i_err_clr clears it.
